// File: rtl/uart_frame_pkg.sv
// Shared types for the UART RX frame parser.
// Holds parser states, error codes and the default start-of-frame marker.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CSUM    = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_rx_frame_parser_if.sv
// Payload byte stream leaving the frame parser.
// The parser drives it as master; the downstream consumer is the slave.
interface uart_rx_frame_parser_if;

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/uart_frame_buf.sv
// Payload holding buffer: one synchronous write port, one async read port.
// Contents are never reset; a frame always overwrites what it reads back.
module uart_frame_buf #(
    parameter  int MAX_LEN = 16,
    localparam int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [MAX_LEN];

    // Store one payload byte per accepted capture.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Pops bytes from the RX FIFO, assembles SOF/LEN/PAYLOAD/CSUM frames and
// releases payload downstream only after the checksum matches.
module uart_rx_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 208333
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_fifo_empty,
    output logic                   rx_rd_en,
    uart_rx_frame_parser_if.master m_if,
    output logic                   frame_ok,
    output logic                   frame_err,
    output logic [1:0]             err_code,
    output logic                   busy
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        r_state,      w_state_nxt;
    logic          r_rd_pending, w_rd_pending_nxt;
    logic [LW-1:0] r_len,        w_len_nxt;
    logic [7:0]    r_sum,        w_sum_nxt;
    logic [AW-1:0] r_wr_idx,     w_wr_idx_nxt;
    logic [AW-1:0] r_rd_idx,     w_rd_idx_nxt;
    logic [TW-1:0] r_timer,      w_timer_nxt;
    logic [7:0]    r_m_data,     w_m_data_nxt;
    logic          r_m_valid,    w_m_valid_nxt;
    logic          r_m_last,     w_m_last_nxt;
    logic          r_frame_ok,   w_frame_ok_nxt;
    logic          r_frame_err,  w_frame_err_nxt;
    err_t          r_err_code,   w_err_code_nxt;

    logic          w_in_frame;
    logic          w_timeout;
    logic          w_cap;
    logic          w_rd_req;
    logic          w_xfer;
    logic          w_len_ok;
    logic          w_last_wr;
    logic [AW-1:0] w_rd_next;
    logic [AW-1:0] w_rd_addr;
    logic [7:0]    w_buf_rdata;
    logic          w_buf_we;

    assign w_in_frame = (r_state == S_LEN) ||
                        (r_state == S_PAYLOAD) ||
                        (r_state == S_CSUM);

    // A byte landing in the expiry cycle is lost: expiry takes priority.
    assign w_timeout = w_in_frame &&
                       (r_timer == TW'(TIMEOUT_CYCLES - 1));
    assign w_cap     = r_rd_pending && !w_timeout;

    // One pop in flight at most; the stream is never fed while draining.
    assign w_rd_req  = (r_state != S_DRAIN) && !rx_fifo_empty &&
                       !r_rd_pending && !w_timeout;
    assign rx_rd_en  = rst && w_rd_req;

    assign w_xfer    = r_m_valid && m_if.m_ready;
    assign w_len_ok  = (rx_data != 8'd0) && (int'(rx_data) <= MAX_LEN);
    assign w_last_wr = (LW'(r_wr_idx) == r_len - LW'(1));
    assign w_rd_next = r_rd_idx + AW'(1);

    // Read address anticipates the byte loaded on the next accepted edge.
    assign w_rd_addr = (r_state == S_DRAIN) ? w_rd_next : '0;
    assign w_buf_we  = w_cap && (r_state == S_PAYLOAD);

    uart_frame_buf #(
        .MAX_LEN (MAX_LEN)
    ) u_buf (
        .clk     (clk),
        .i_we    (w_buf_we),
        .i_waddr (r_wr_idx),
        .i_wdata (rx_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_buf_rdata)
    );

    // Next-state and next-output decode for the frame FSM.
    always_comb begin
        w_state_nxt      = r_state;
        w_rd_pending_nxt = w_rd_req;
        w_len_nxt        = r_len;
        w_sum_nxt        = r_sum;
        w_wr_idx_nxt     = r_wr_idx;
        w_rd_idx_nxt     = r_rd_idx;
        w_timer_nxt      = r_timer;
        w_m_data_nxt     = r_m_data;
        w_m_valid_nxt    = r_m_valid;
        w_m_last_nxt     = r_m_last;
        w_frame_ok_nxt   = 1'b0;
        w_frame_err_nxt  = 1'b0;
        w_err_code_nxt   = r_err_code;

        if (w_in_frame) begin
            w_timer_nxt = r_timer + TW'(1);
        end
        if (w_cap) begin
            w_timer_nxt = '0;
        end

        unique case (r_state)
            S_HUNT: begin
                if (w_cap && rx_data == SOF_BYTE) begin
                    w_state_nxt = S_LEN;
                    w_sum_nxt   = 8'd0;
                    w_timer_nxt = '0;
                end
            end
            S_LEN: begin
                if (w_cap) begin
                    if (w_len_ok) begin
                        w_len_nxt    = LW'(rx_data);
                        w_sum_nxt    = rx_data;
                        w_wr_idx_nxt = '0;
                        w_state_nxt  = S_PAYLOAD;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_err_code_nxt  = ERR_LEN;
                        w_state_nxt     = S_HUNT;
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_cap) begin
                    w_sum_nxt    = r_sum + rx_data;
                    w_wr_idx_nxt = r_wr_idx + AW'(1);
                    if (w_last_wr) begin
                        w_state_nxt = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (w_cap) begin
                    if (rx_data == r_sum) begin
                        w_frame_ok_nxt = 1'b1;
                        w_rd_idx_nxt   = '0;
                        w_m_valid_nxt  = 1'b1;
                        w_m_data_nxt   = w_buf_rdata;
                        w_m_last_nxt   = (r_len == LW'(1));
                        w_state_nxt    = S_DRAIN;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_err_code_nxt  = ERR_CSUM;
                        w_state_nxt     = S_HUNT;
                    end
                end
            end
            S_DRAIN: begin
                if (w_xfer) begin
                    if (r_m_last) begin
                        w_m_valid_nxt = 1'b0;
                        w_m_last_nxt  = 1'b0;
                        w_state_nxt   = S_HUNT;
                    end else begin
                        w_rd_idx_nxt = w_rd_next;
                        w_m_data_nxt = w_buf_rdata;
                        w_m_last_nxt = (LW'(w_rd_next) ==
                                        r_len - LW'(1));
                    end
                end
            end
            default: begin
                w_state_nxt = S_HUNT;
            end
        endcase

        if (w_timeout) begin
            w_frame_ok_nxt  = 1'b0;
            w_frame_err_nxt = 1'b1;
            w_err_code_nxt  = ERR_TIMEOUT;
            w_timer_nxt     = '0;
            w_state_nxt     = S_HUNT;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_HUNT;
            r_rd_pending <= 1'b0;
            r_len        <= '0;
            r_sum        <= 8'd0;
            r_wr_idx     <= '0;
            r_rd_idx     <= '0;
            r_timer      <= '0;
            r_m_data     <= 8'd0;
            r_m_valid    <= 1'b0;
            r_m_last     <= 1'b0;
            r_frame_ok   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_code   <= ERR_NONE;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_pending <= w_rd_pending_nxt;
            r_len        <= w_len_nxt;
            r_sum        <= w_sum_nxt;
            r_wr_idx     <= w_wr_idx_nxt;
            r_rd_idx     <= w_rd_idx_nxt;
            r_timer      <= w_timer_nxt;
            r_m_data     <= w_m_data_nxt;
            r_m_valid    <= w_m_valid_nxt;
            r_m_last     <= w_m_last_nxt;
            r_frame_ok   <= w_frame_ok_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_err_code   <= w_err_code_nxt;
        end
    end

    assign m_if.m_data  = r_m_data;
    assign m_if.m_valid = r_m_valid;
    assign m_if.m_last  = r_m_last;
    assign frame_ok     = r_frame_ok;
    assign frame_err    = r_frame_err;
    assign err_code     = r_err_code;
    assign busy         = (r_state != S_HUNT);

endmodule
